// File: rtl/joybus_device_engine.sv
// Joybus (N64) device-side engine: decodes console commands on the oversampled line and
// answers INFO/RESET/STATUS on an open-drain output. Define JOYBUS_PAK_EN for accessory READ/WRITE.
module joybus_device_engine #(
    parameter int          LEVEL_WIDTH       = 2,
    parameter int          TURNAROUND_LEVELS = 4,
    parameter int          IDLE_LEVELS       = 8,
    parameter logic [15:0] DEVICE_ID         = 16'h0500
) (
    input  logic        sample_clk,
    input  logic        reset_n,
    input  logic        data_rx,
    input  logic [15:0] buttons,
    input  logic [7:0]  stick_x,
    input  logic [7:0]  stick_y,
    output logic        data_oe,
    output logic        tx_busy,
    output logic        cmd_valid,
    output logic [7:0]  cmd
);
    localparam int SAMP_CYC = 2 * LEVEL_WIDTH;
    localparam int IDLE_CYC = IDLE_LEVELS * LEVEL_WIDTH;
    localparam int TA_CYC   = TURNAROUND_LEVELS * LEVEL_WIDTH;
`ifdef JOYBUS_PAK_EN
    localparam int          RX_BITS_MAX  = 35 * 8;
    localparam int          TX_BYTES_MAX = 33;
    localparam logic [7:0]  PAK_BYTE     = 8'h01;
`else
    localparam int          RX_BITS_MAX  = 8;
    localparam int          TX_BYTES_MAX = 4;
    localparam logic [7:0]  PAK_BYTE     = 8'h02;
`endif
    localparam int TX_W = TX_BYTES_MAX * 8;
    localparam int SW   = $clog2(SAMP_CYC + 1);
    localparam int HW   = $clog2(IDLE_CYC + 1);
    localparam int TW   = $clog2(TA_CYC + LEVEL_WIDTH + 1);
    localparam int RBW  = $clog2(RX_BITS_MAX + 1);
    localparam int TBW  = $clog2(TX_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_RX_CMD, ST_RX_ARGS, ST_RX_STOP,
        ST_TURNAROUND, ST_TX_DATA, ST_TX_STOP, ST_WAIT_IDLE
    } state_t;

`ifdef JOYBUS_PAK_EN
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        crc8_step = {crc[6:0], 1'b0} ^ (((crc[7] ^ bit_in) == 1'b1) ? 8'h85 : 8'h00);
    endfunction
    logic [7:0] crc_q, crc_d;
`endif

    state_t            state_q, state_d;
    logic [1:0]        sync_q;
    logic              prev_q;
    logic              samp_act_q, samp_act_d;
    logic [SW-1:0]     samp_q, samp_d;
    logic [HW-1:0]     hi_q, hi_d;
    logic [RBW-1:0]    rxb_q, rxb_d;
    logic [6:0]        sh_q, sh_d;
    logic [7:0]        pend_q, pend_d;
    logic [TX_W-1:0]   tx_q, tx_d;
    logic [TBW-1:0]    txb_q, txb_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [1:0]        qtr_q, qtr_d;
    logic              oe_q, oe_d, busy_q, busy_d, cv_q, cv_d;
    logic [7:0]        cmd_q, cmd_d;

    logic rx_s, fall_s, bit_done_s, idle_s, rx_state_s;
    logic [7:0] byte_s;

    assign rx_s       = sync_q[1];
    // Our own transmission echoes back on the line; ignore it while busy.
    assign fall_s     = prev_q & ~rx_s & ~busy_q;
    assign bit_done_s = samp_act_q & (samp_q == '0);
    assign idle_s     = (hi_q == HW'(IDLE_CYC));
    assign byte_s     = {sh_q, rx_s};
    assign rx_state_s = (state_q == ST_IDLE) || (state_q == ST_RX_CMD) ||
                        (state_q == ST_RX_ARGS) || (state_q == ST_RX_STOP);

    // Two-flop synchroniser and edge history; idles high like the line.
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], data_rx};
            prev_q <= sync_q[1];
        end
    end

    // Next-state logic for the frame FSM, bit timers and transmit shifter.
    always_comb begin
        state_d = state_q;  samp_act_d = samp_act_q;  samp_d = samp_q;
        hi_d = hi_q;        rxb_d = rxb_q;            sh_d = sh_q;
        pend_d = pend_q;    tx_d = tx_q;              txb_d = txb_q;
        tmr_d = tmr_q;      qtr_d = qtr_q;            cmd_d = cmd_q;
        cv_d = 1'b0;        oe_d = 1'b0;
`ifdef JOYBUS_PAK_EN
        crc_d = crc_q;
`endif
        if (rx_s && !busy_q) begin
            if (!idle_s) hi_d = hi_q + HW'(1); else hi_d = hi_q;
        end else begin
            hi_d = '0;
        end
        if (samp_act_q) begin
            if (samp_q == '0) samp_act_d = 1'b0; else samp_d = samp_q - SW'(1);
        end else if (fall_s && rx_state_s) begin
            samp_act_d = 1'b1;
            samp_d     = SW'(SAMP_CYC - 1);
        end else begin
            samp_act_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_s) begin
                    state_d = ST_RX_CMD;
                    rxb_d   = '0;
`ifdef JOYBUS_PAK_EN
                    crc_d   = 8'h00;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RX_CMD: begin
                if (bit_done_s) begin
                    sh_d  = byte_s[6:0];
                    rxb_d = rxb_q + RBW'(1);
                    if (rxb_q == RBW'(7)) begin
                        pend_d = byte_s;
                        case (byte_s)
                            8'h00, 8'hFF, 8'h01: state_d = ST_RX_STOP;
`ifdef JOYBUS_PAK_EN
                            8'h02, 8'h03:        state_d = ST_RX_ARGS;
`endif
                            default:             state_d = ST_WAIT_IDLE;
                        endcase
                    end else begin
                        state_d = ST_RX_CMD;
                    end
                end else if (idle_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RX_CMD;
                end
            end
            ST_RX_ARGS: begin
`ifdef JOYBUS_PAK_EN
                if (bit_done_s) begin
                    sh_d  = byte_s[6:0];
                    rxb_d = rxb_q + RBW'(1);
                    // Only the WRITE payload (after cmd + 2 address bytes) feeds the CRC.
                    if (rxb_q >= RBW'(24)) crc_d = crc8_step(crc_q, rx_s); else crc_d = crc_q;
                    if (rxb_q == ((pend_q == 8'h02) ? RBW'(23) : RBW'(279))) state_d = ST_RX_STOP;
                    else state_d = ST_RX_ARGS;
                end else if (idle_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RX_ARGS;
                end
`else
                state_d = ST_WAIT_IDLE;
`endif
            end
            ST_RX_STOP: begin
                if (bit_done_s) begin
                    if (rx_s) begin
                        cv_d    = 1'b1;
                        cmd_d   = pend_q;
                        tmr_d   = TW'(TA_CYC - 2);
                        state_d = ST_TURNAROUND;
                        tx_d    = '0;
                        case (pend_q)
                            8'h01: begin
                                tx_d[TX_W-1 -: 32] = {buttons, stick_x, stick_y};
                                txb_d = TBW'(32);
                            end
`ifdef JOYBUS_PAK_EN
                            8'h02: txb_d = TBW'(264);
                            8'h03: begin
                                tx_d[TX_W-1 -: 8] = crc_q;
                                txb_d = TBW'(8);
                            end
`endif
                            default: begin
                                tx_d[TX_W-1 -: 24] = {DEVICE_ID, PAK_BYTE};
                                txb_d = TBW'(24);
                            end
                        endcase
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end else if (idle_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RX_STOP;
                end
            end
            // The schedule runs one cycle ahead of data_oe, which is registered.
            ST_TURNAROUND: begin
                if (tmr_q == '0) begin
                    state_d = ST_TX_DATA;
                    tmr_d   = TW'(LEVEL_WIDTH - 1);
                    qtr_d   = 2'd0;
                end else begin
                    tmr_d   = tmr_q - TW'(1);
                end
            end
            ST_TX_DATA: begin
                oe_d = (qtr_q == 2'd0) || ((qtr_q != 2'd3) && !tx_q[TX_W-1]);
                if (tmr_q == '0) begin
                    tmr_d = TW'(LEVEL_WIDTH - 1);
                    if (qtr_q == 2'd3) begin
                        qtr_d = 2'd0;
                        tx_d  = tx_q << 1;
                        txb_d = txb_q - TBW'(1);
                        if (txb_q == TBW'(1)) state_d = ST_TX_STOP; else state_d = ST_TX_DATA;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ST_TX_STOP: begin
                oe_d = (qtr_q != 2'd2);
                if (tmr_q == '0) begin
                    tmr_d = TW'(LEVEL_WIDTH - 1);
                    if (qtr_q == 2'd2) state_d = ST_WAIT_IDLE; else qtr_d = qtr_q + 2'd1;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (idle_s) state_d = ST_IDLE; else state_d = ST_WAIT_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Busy extends one cycle past the stop schedule so it covers the last visible level.
        busy_d = (state_d == ST_TURNAROUND) || (state_d == ST_TX_DATA) ||
                 (state_d == ST_TX_STOP) || (state_q == ST_TX_STOP);
    end

    // State and output registers; reset releases the line immediately.
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;  samp_act_q <= 1'b0;  samp_q <= '0;   hi_q <= '0;
            rxb_q <= '0;         sh_q <= '0;          pend_q <= 8'h00;
            tx_q <= '0;          txb_q <= '0;         tmr_q <= '0;    qtr_q <= 2'd0;
            oe_q <= 1'b0;        busy_q <= 1'b0;      cv_q <= 1'b0;   cmd_q <= 8'h00;
`ifdef JOYBUS_PAK_EN
            crc_q <= 8'h00;
`endif
        end else begin
            state_q <= state_d;  samp_act_q <= samp_act_d;  samp_q <= samp_d;  hi_q <= hi_d;
            rxb_q <= rxb_d;      sh_q <= sh_d;              pend_q <= pend_d;
            tx_q <= tx_d;        txb_q <= txb_d;            tmr_q <= tmr_d;    qtr_q <= qtr_d;
            oe_q <= oe_d;        busy_q <= busy_d;          cv_q <= cv_d;      cmd_q <= cmd_d;
`ifdef JOYBUS_PAK_EN
            crc_q <= crc_d;
`endif
        end
    end

    assign data_oe   = oe_q;
    assign tx_busy   = busy_q;
    assign cmd_valid = cv_q;
    assign cmd       = cmd_q;
endmodule

// File: tb/tb_joybus_device_engine.sv
// Bench for joybus_device_engine: drives console frames on a wired-AND line and checks
// replies against a level-by-level waveform model built from the expected reply bytes.
module tb_joybus_device_engine;
    localparam int LW   = 2;
    localparam int TAL  = 4;
    localparam int IDL  = 8;
    localparam int TA   = TAL * LW;
    localparam int BITC = 4 * LW;
    localparam int MAXC = 32768;
`ifdef JOYBUS_PAK_EN
    localparam logic [7:0] PAK = 8'h01;
`else
    localparam logic [7:0] PAK = 8'h02;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, con_low, data_rx, data_oe, tx_busy, cmd_valid;
    logic [15:0] buttons;
    logic [7:0]  stick_x, stick_y, cmd;
    assign data_rx = ~(con_low | data_oe);

    joybus_device_engine #(.LEVEL_WIDTH(LW), .TURNAROUND_LEVELS(TAL), .IDLE_LEVELS(IDL),
                           .DEVICE_ID(16'h0500)) dut (
        .sample_clk(clk), .reset_n(rst_n), .data_rx(data_rx), .buttons(buttons),
        .stick_x(stick_x), .stick_y(stick_y), .data_oe(data_oe), .tx_busy(tx_busy),
        .cmd_valid(cmd_valid), .cmd(cmd));

    int n_chk = 0, n_pass = 0;
    int cyc_n = 0, cv_cnt = 0, cv_cyc = 0;
    logic oe_h [0:MAXC-1];
    logic bz_h [0:MAXC-1];
    logic [7:0] exp_q [$];

    // History recorder: one entry per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (cyc_n < MAXC) begin
            oe_h[cyc_n] <= data_oe;
            bz_h[cyc_n] <= tx_busy;
        end
        if (cmd_valid) begin
            cv_cnt <= cv_cnt + 1;
            cv_cyc <= cyc_n;
        end
        cyc_n <= cyc_n + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic send_bit(input logic v);
        for (int q = 0; q < 4; q++) begin
            con_low = (q == 0) || (q < 3 && !v);
            cyc(LW);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_stop(input logic v);
        con_low = 1'b1; cyc(LW);
        con_low = ~v;   cyc(2 * LW);
        con_low = 1'b0; cyc(LW);
    endtask

    function automatic logic [7:0] crc_model(input logic [7:0] data [$]);
        logic [7:0] c;
        c = 8'h00;
        foreach (data[i]) for (int k = 7; k >= 0; k--)
            c = ((c[7] ^ data[i][k]) == 1'b1) ? ((c << 1) ^ 8'h85) : (c << 1);
        return c;
    endfunction

    // Waits for the accept pulse, scrambles pad inputs, then checks the whole reply waveform.
    task automatic expect_reply(input string tag, input int cv0, input logic [7:0] ecmd);
        int p, nb, total, mism, busy, j, bi, lv;
        logic e;
        logic [7:0] ob;
        for (int k = 0; k < 100 && cv_cnt == cv0; k++) cyc(1);
        chk({tag, "_cv"}, cv_cnt - cv0, 1);
        if (cv_cnt != cv0) begin
            buttons = 16'($urandom); stick_x = 8'($urandom); stick_y = 8'($urandom);
            chk({tag, "_cmd"}, cmd, ecmd);
            p = cv_cyc; nb = exp_q.size() * 8; total = TA + nb * BITC + 3 * LW;
            while (cyc_n < p + total + 6) cyc(1);
            mism = 0; busy = 0;
            for (int k = 0; k < total + 4; k++) begin
                if (k < TA) e = 1'b0;
                else if (k - TA < nb * BITC) begin
                    j = k - TA; bi = j / BITC; lv = (j % BITC) / LW;
                    ob = exp_q[bi / 8];
                    e = (lv == 0) || (lv < 3 && !ob[7 - (bi % 8)]);
                end else begin
                    lv = (k - TA - nb * BITC) / LW;
                    e = (lv < 2);
                end
                if (oe_h[p + k] !== e) mism++;
                if (bz_h[p + k] === 1'b1) busy++;
            end
            chk({tag, "_wave_mism"}, mism, 0);
            chk({tag, "_busy_len"}, busy, total);
            chk({tag, "_busy_pre"}, bz_h[p - 1], 0);
            for (int b = 0; b < exp_q.size(); b++) begin
                for (int i = 0; i < 8; i++) ob[7 - i] = ~oe_h[p + TA + (b * 8 + i) * BITC + 2 * LW];
                chk($sformatf("%s_byte%0d", tag, b), ob, exp_q[b]);
            end
        end
        cyc(IDL * LW + 8);
    endtask

    task automatic expect_silence(input string tag, input int cv0, input int s0);
        int highs;
        cyc(TA + 40);
        chk({tag, "_no_cv"}, cv_cnt - cv0, 0);
        highs = 0;
        for (int k = s0; k < cyc_n; k++) if (oe_h[k] === 1'b1) highs++;
        chk({tag, "_no_oe"}, highs, 0);
        cyc(IDL * LW + 8);
    endtask

    initial begin
        int cv0, s0, p, tgt;
        logic [7:0] wd [$];
        rst_n = 1'b0; con_low = 1'b0;
        buttons = 16'h0000; stick_x = 8'h00; stick_y = 8'h00;
        cyc(3);
        chk("rst_oe", data_oe, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_cv", cmd_valid, 0);
        chk("rst_cmd", cmd, 8'h00);
        rst_n = 1'b1;
        cyc(20);

        // INFO
        exp_q = {8'h05, 8'h00, PAK};
        cv0 = cv_cnt; send_byte(8'h00); send_stop(1'b1);
        expect_reply("info00", cv0, 8'h00);

        // STATUS, directed then random pad states
        buttons = 16'h8001; stick_x = 8'h7F; stick_y = 8'h80;
        exp_q = {8'h80, 8'h01, 8'h7F, 8'h80};
        cv0 = cv_cnt; send_byte(8'h01); send_stop(1'b1);
        expect_reply("status_dir", cv0, 8'h01);
        for (int r = 0; r < 3; r++) begin
            buttons = 16'($urandom); stick_x = 8'($urandom); stick_y = 8'($urandom);
            exp_q = {buttons[15:8], buttons[7:0], stick_x, stick_y};
            cv0 = cv_cnt; send_byte(8'h01); send_stop(1'b1);
            expect_reply($sformatf("status_rnd%0d", r), cv0, 8'h01);
        end

        // Unknown command, then a normal STATUS
        cv0 = cv_cnt; s0 = cyc_n; send_byte(8'h42); send_stop(1'b1);
        expect_silence("unk42", cv0, s0);
        buttons = 16'h1234; stick_x = 8'hF0; stick_y = 8'h0F;
        exp_q = {8'h12, 8'h34, 8'hF0, 8'h0F};
        cv0 = cv_cnt; send_byte(8'h01); send_stop(1'b1);
        expect_reply("status_after_unk", cv0, 8'h01);

        // Stop bit sampled low
        cv0 = cv_cnt; s0 = cyc_n; send_byte(8'h01); send_stop(1'b0);
        expect_silence("badstop", cv0, s0);

        // Partial frame timeout, then RESET answered with INFO
        cv0 = cv_cnt; s0 = cyc_n;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        cyc(16);
        exp_q = {8'h05, 8'h00, PAK};
        send_byte(8'hFF); send_stop(1'b1);
        expect_reply("timeout_then_ff", cv0, 8'hFF);

        // Reset in the middle of the second STATUS byte
        buttons = 16'hA5C3; stick_x = 8'h01; stick_y = 8'hFE;
        cv0 = cv_cnt; send_byte(8'h01); send_stop(1'b1);
        for (int k = 0; k < 100 && cv_cnt == cv0; k++) cyc(1);
        chk("rstmid_cv", cv_cnt - cv0, 1);
        p = cv_cyc; tgt = p + TA + 9 * BITC;
        while (cyc_n - 1 < tgt) cyc(1);
        chk("rstmid_pre_oe", data_oe, 1);
        rst_n = 1'b0; #1;
        chk("rstmid_oe", data_oe, 0);
        chk("rstmid_busy", tx_busy, 0);
        chk("rstmid_cv0", cmd_valid, 0);
        chk("rstmid_cmd", cmd, 8'h00);
        cyc(3); rst_n = 1'b1; cyc(IDL * LW + 8);
        exp_q = {8'h05, 8'h00, PAK};
        cv0 = cv_cnt; send_byte(8'hFF); send_stop(1'b1);
        expect_reply("info_after_rst", cv0, 8'hFF);

        // Accessory READ and WRITE
        cv0 = cv_cnt; s0 = cyc_n;
        send_byte(8'h02); send_byte(8'h80); send_byte(8'h01); send_stop(1'b1);
`ifdef JOYBUS_PAK_EN
        exp_q = {};
        for (int i = 0; i < 33; i++) exp_q.push_back(8'h00);
        expect_reply("pak_read", cv0, 8'h02);
`else
        expect_silence("pak_read", cv0, s0);
`endif
        for (int w = 0; w < 2; w++) begin
            wd = {};
            for (int i = 0; i < 32; i++) wd.push_back((w == 0) ? 8'h00 : 8'($urandom));
            cv0 = cv_cnt; s0 = cyc_n;
            send_byte(8'h03); send_byte(8'h80); send_byte(8'h01);
            foreach (wd[i]) send_byte(wd[i]);
            send_stop(1'b1);
`ifdef JOYBUS_PAK_EN
            exp_q = {crc_model(wd)};
            expect_reply($sformatf("pak_write%0d", w), cv0, 8'h03);
`else
            expect_silence($sformatf("pak_write%0d", w), cv0, s0);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
